// File: rtl/iter_shift_if.sv
// Handshake bundle for iter_shift_unit: operand/op/amount in, result out.
// Flag signals exist only when SHIFT_FLAGS_EN is defined.
interface iter_shift_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFT_FLAGS_EN
  logic             out_carry;
  logic             out_zero;
`endif

  modport master (
    output in_valid, in_data, op, amt, out_ready,
    input  in_ready, out_valid, out_data
`ifdef SHIFT_FLAGS_EN
    , input out_carry, out_zero
`endif
  );

  modport slave (
    input  in_valid, in_data, op, amt, out_ready,
    output in_ready, out_valid, out_data
`ifdef SHIFT_FLAGS_EN
    , output out_carry, out_zero
`endif
  );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit, up to STEP bits per clock, valid/ready in and out.
// Optional carry/zero flags are built when the macro SHIFT_FLAGS_EN is defined.
module iter_shift_unit #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        reset,
  iter_shift_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] rem_r;
  logic [AMT_W-1:0] step_s;
  logic [WIDTH-1:0] shift_val_s;
  logic             in_ready_s, out_valid_s;

  // One step of s bits; s is never 0 while shifting.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0] o,
                                                input logic [AMT_W-1:0] s);
    logic [WIDTH-1:0] r;
    logic [AMT_W:0]   inv;
    inv = (AMT_W+1)'(WIDTH) - {1'b0, s};
    case (o)
      2'b00:   r = (d >> s) | (d << inv);
      2'b01:   r = d << s;
      2'b10:   r = d >> s;
      2'b11:   r = $unsigned($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  assign step_s      = (rem_r > STEP_A) ? STEP_A : rem_r;
  assign shift_val_s = shift_by(data_r, op_r, step_s);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next_s = (bus.amt == {AMT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_r == step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready_s  = 1'b1;
      ST_DONE:  out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Operand/result register and remaining-count
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {WIDTH{1'b0}};
      op_r   <= 2'b00;
      rem_r  <= {AMT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_r <= bus.in_data;
            op_r   <= bus.op;
            rem_r  <= bus.amt;
          end
        end
        ST_SHIFT: begin
          data_r <= shift_val_s;
          rem_r  <= rem_r - step_s;
        end
        default: begin
          data_r <= data_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = data_r;

`ifdef SHIFT_FLAGS_EN
  logic carry_r, zero_r, carry_s;

  // Bit leaving the word this step; the last step's value is the final carry.
  // For ROR the bit leaving bit s-1 lands in the result MSB, so it shares the right-shift form.
  function automatic logic step_carry(input logic [WIDTH-1:0] d,
                                      input logic [1:0] o,
                                      input logic [AMT_W-1:0] s);
    logic [WIDTH-1:0] t;
    logic [AMT_W:0]   inv;
    inv = (AMT_W+1)'(WIDTH) - {1'b0, s};
    case (o)
      2'b01:   t = d >> inv;
      default: t = d >> (s - AMT_W'(1));
    endcase
    return t[0];
  endfunction

  assign carry_s = step_carry(data_r, op_r, step_s);

  // Flags registered alongside the data
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_r <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            carry_r <= 1'b0;
            zero_r  <= (bus.in_data == {WIDTH{1'b0}});
          end
        end
        ST_SHIFT: begin
          carry_r <= carry_s;
          zero_r  <= (shift_val_s == {WIDTH{1'b0}});
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

  assign bus.out_carry = carry_r;
  assign bus.out_zero  = zero_r;
`endif
endmodule
